// File: rtl/porownanie_pkg.sv
// porownanie_pkg: shared state encoding, defaults and sizing helper for the comparator arbiter
package porownanie_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} arb_state_t;
  localparam int BITS_DEF = 32;
  localparam int N_REQ_DEF = 4;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/porownanie_arbiter_if.sv
// porownanie_arbiter_if: requester-side request/response handshakes of the comparator arbiter
interface porownanie_arbiter_if import porownanie_pkg::*; #(
  parameter int BITS = BITS_DEF,
  parameter int N_REQ = N_REQ_DEF
) ();
  logic [N_REQ-1:0] i_req_valid;
  logic [N_REQ-1:0] o_req_ready;
  logic [N_REQ*BITS-1:0] i_req_arg_A;
  logic [N_REQ*BITS-1:0] i_req_arg_B;
  logic [N_REQ-1:0] o_rsp_valid;
  logic [N_REQ-1:0] i_rsp_ready;
  logic o_rsp_result;
  logic o_busy;
  modport master (
    output i_req_valid, i_req_arg_A, i_req_arg_B, i_rsp_ready,
    input o_req_ready, o_rsp_valid, o_rsp_result, o_busy
  );
  modport slave (
    input i_req_valid, i_req_arg_A, i_req_arg_B, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_busy
  );
endinterface

// File: rtl/porownanie.sv
// porownanie: unsigned magnitude comparator, o_result = i_arg_A > i_arg_B
module porownanie #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic            o_result
);
  assign o_result = i_arg_A > i_arg_B;
endmodule

// File: rtl/porownanie_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at i_ptr, one-hot grant plus index
module rr_arbiter import porownanie_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);
  int j;
  // walk from lowest to highest priority so the highest-priority requester is written last
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(i_ptr) + i) % N_REQ;
      if (i_req[j]) begin
        o_gnt = '0;
        o_gnt[j] = 1'b1;
        o_idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/porownanie_arbiter.sv
// porownanie_arbiter: round-robin sharing of one porownanie comparator between N_REQ requesters
module porownanie_arbiter import porownanie_pkg::*; #(
  parameter int BITS = BITS_DEF,
  parameter int N_REQ = N_REQ_DEF
) (
  input logic i_clk,
  input logic i_rsn,
  porownanie_arbiter_if.slave bus
);
  localparam int IW = idx_w(N_REQ);
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, g_q, g_d, gidx;
  logic [BITS-1:0] a_q, a_d, b_q, b_d;
  logic res_q, res_d, cmp_res;
  logic [N_REQ-1:0] gnt, req_ready, rsp_valid;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req(bus.i_req_valid), .i_ptr(ptr_q), .o_gnt(gnt), .o_idx(gidx)
  );
  porownanie #(.BITS(BITS)) u_cmp (.i_arg_A(a_q), .i_arg_B(b_q), .o_result(cmp_res));
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: if (|bus.i_req_valid) begin
        req_ready = gnt;
        g_d = gidx;
        a_d = bus.i_req_arg_A[int'(gidx)*BITS +: BITS];
        b_d = bus.i_req_arg_B[int'(gidx)*BITS +: BITS];
        state_d = EVAL;
      end
      EVAL: begin
        res_d = cmp_res;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        // priority moves past the served requester only once its response is taken
        if (bus.i_rsp_ready[g_q]) begin
          state_d = IDLE;
          ptr_d = IW'((int'(g_q) + 1) % N_REQ);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      state_q <= IDLE;
      ptr_q <= '0;
      g_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
    end
  end
  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_result = (state_q == RESP) && res_q;
  assign bus.o_busy = state_q != IDLE;
endmodule

// File: tb/tb_porownanie_arbiter.sv
// tb_porownanie_arbiter: directed scenarios plus randomized regression against a transaction-level model
module tb_porownanie_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic i_clk = 1'b0;
  logic i_rsn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int ptr_m = 0;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  always #5 i_clk = ~i_clk;

  porownanie_arbiter_if #(.BITS(W), .N_REQ(N)) bus ();
  porownanie_arbiter #(.BITS(W), .N_REQ(N)) dut (.i_clk(i_clk), .i_rsn(i_rsn), .bus(bus));

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.i_req_valid[k] = 1'b1;
    bus.i_req_arg_A[k*W +: W] = a;
    bus.i_req_arg_B[k*W +: W] = b;
    opa[k] = a;
    opb[k] = b;
  endtask

  task automatic test_reset();
    i_rsn = 1'b0;
    bus.i_req_valid = '0;
    bus.i_rsp_ready = '0;
    bus.i_req_arg_A = '0;
    bus.i_req_arg_B = '0;
    step();
    step();
    @(negedge i_clk);
    vectors++; if (bus.o_req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", bus.o_req_ready); end
    vectors++; if (bus.o_rsp_valid !== '0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0000", bus.o_rsp_valid); end
    vectors++; if (bus.o_rsp_result !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_result got %b want 0", bus.o_rsp_result); end
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    step();
    i_rsn = 1'b1;
    ptr_m = 0;
  endtask

  task automatic test_single();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [N-1:0] exp_r;
    av = '{32'd5, 32'd3, 32'd7};
    bv = '{32'd3, 32'd5, 32'd7};
    for (int t = 0; t < 3; t++) begin
      set_req(1, av[t], bv[t]);
      exp_r = N'(1) << winner(bus.i_req_valid, ptr_m);
      @(negedge i_clk);
      vectors++; if (bus.o_req_ready !== exp_r) begin miscompares++; $display("FAIL single_ready[%0d] got %b want %b", t, bus.o_req_ready, exp_r); end
      step();
      bus.i_req_valid[1] = 1'b0;
      @(negedge i_clk);
      vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL single_eval_busy[%0d] got %b want 1", t, bus.o_busy); end
      vectors++; if (bus.o_rsp_valid !== '0) begin miscompares++; $display("FAIL single_eval_rsp[%0d] got %b want 0000", t, bus.o_rsp_valid); end
      step();
      @(negedge i_clk);
      vectors++; if (bus.o_rsp_valid !== 4'b0010) begin miscompares++; $display("FAIL single_rsp_valid[%0d] got %b want 0010", t, bus.o_rsp_valid); end
      vectors++; if (bus.o_rsp_result !== (av[t] > bv[t])) begin miscompares++; $display("FAIL single_result[%0d] got %b want %b", t, bus.o_rsp_result, av[t] > bv[t]); end
      bus.i_rsp_ready = 4'b0010;
      step();
      bus.i_rsp_ready = '0;
      ptr_m = 2;
      @(negedge i_clk);
      vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL single_done_busy[%0d] got %b want 0", t, bus.o_busy); end
      step();
    end
  endtask

  task automatic test_contention();
    int order [7];
    int g;
    order = '{0, 2, 3, 0, 1, 2, 3};
    i_rsn = 1'b0;
    step();
    i_rsn = 1'b1;
    ptr_m = 0;
    set_req(0, $urandom, $urandom);
    set_req(2, $urandom, $urandom);
    set_req(3, $urandom, $urandom);
    for (int t = 0; t < 7; t++) begin
      if (t == 3) for (int k = 0; k < N; k++) set_req(k, $urandom, $urandom);
      g = order[t];
      @(negedge i_clk);
      vectors++; if (bus.o_req_ready !== (N'(1) << g)) begin miscompares++; $display("FAIL contention_grant[%0d] got %b want %b", t, bus.o_req_ready, N'(1) << g); end
      step();
      bus.i_req_valid[g] = 1'b0;
      step();
      @(negedge i_clk);
      vectors++; if (bus.o_rsp_valid !== (N'(1) << g)) begin miscompares++; $display("FAIL contention_rsp[%0d] got %b want %b", t, bus.o_rsp_valid, N'(1) << g); end
      vectors++; if (bus.o_rsp_result !== (opa[g] > opb[g])) begin miscompares++; $display("FAIL contention_result[%0d] got %b want %b", t, bus.o_rsp_result, opa[g] > opb[g]); end
      bus.i_rsp_ready = '1;
      step();
      bus.i_rsp_ready = '0;
      ptr_m = (g + 1) % N;
    end
  endtask

  task automatic test_backpressure();
    set_req(2, 32'd9, 32'd1);
    @(negedge i_clk);
    vectors++; if (bus.o_req_ready !== 4'b0100) begin miscompares++; $display("FAIL bp_grant got %b want 0100", bus.o_req_ready); end
    step();
    bus.i_req_valid[2] = 1'b0;
    set_req(0, 32'd4, 32'd6);
    step();
    for (int c = 0; c < 5; c++) begin
      bus.i_rsp_ready = 4'b1011;
      @(negedge i_clk);
      vectors++; if (bus.o_rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL bp_hold_valid[%0d] got %b want 0100", c, bus.o_rsp_valid); end
      vectors++; if (bus.o_rsp_result !== 1'b1) begin miscompares++; $display("FAIL bp_hold_result[%0d] got %b want 1", c, bus.o_rsp_result); end
      vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL bp_hold_busy[%0d] got %b want 1", c, bus.o_busy); end
      vectors++; if (bus.o_req_ready !== '0) begin miscompares++; $display("FAIL bp_hold_ready[%0d] got %b want 0000", c, bus.o_req_ready); end
      step();
    end
    bus.i_rsp_ready = 4'b0100;
    @(negedge i_clk);
    vectors++; if (bus.o_req_ready !== '0) begin miscompares++; $display("FAIL bp_accept_ready got %b want 0000", bus.o_req_ready); end
    step();
    bus.i_rsp_ready = '0;
    ptr_m = 3;
    @(negedge i_clk);
    vectors++; if (bus.o_req_ready !== (N'(1) << winner(bus.i_req_valid, ptr_m))) begin miscompares++; $display("FAIL bp_next_grant got %b want 0001", bus.o_req_ready); end
    step();
    bus.i_req_valid[0] = 1'b0;
    step();
    @(negedge i_clk);
    vectors++; if (bus.o_rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL bp_next_rsp got %b want 0001", bus.o_rsp_valid); end
    vectors++; if (bus.o_rsp_result !== 1'b0) begin miscompares++; $display("FAIL bp_next_result got %b want 0", bus.o_rsp_result); end
    bus.i_rsp_ready = 4'b0001;
    step();
    bus.i_rsp_ready = '0;
    ptr_m = 1;
  endtask

  task automatic test_reset_mid();
    set_req(3, 32'd100, 32'd2);
    @(negedge i_clk);
    vectors++; if (bus.o_req_ready !== (N'(1) << winner(bus.i_req_valid, ptr_m))) begin miscompares++; $display("FAIL rmid_grant got %b want 1000", bus.o_req_ready); end
    step();
    bus.i_req_valid[3] = 1'b0;
    i_rsn = 1'b0;
    step();
    @(negedge i_clk);
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", bus.o_busy); end
    vectors++; if (bus.o_rsp_valid !== '0) begin miscompares++; $display("FAIL rmid_rsp got %b want 0000", bus.o_rsp_valid); end
    vectors++; if (bus.o_req_ready !== '0) begin miscompares++; $display("FAIL rmid_ready got %b want 0000", bus.o_req_ready); end
    vectors++; if (bus.o_rsp_result !== 1'b0) begin miscompares++; $display("FAIL rmid_result got %b want 0", bus.o_rsp_result); end
    step();
    i_rsn = 1'b1;
    ptr_m = 0;
    set_req(0, 32'd1, 32'd0);
    set_req(3, 32'd2, 32'd8);
    @(negedge i_clk);
    vectors++; if (bus.o_req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_first_grant got %b want 0001", bus.o_req_ready); end
    vectors++; if (bus.o_rsp_valid !== '0) begin miscompares++; $display("FAIL rmid_stale_rsp got %b want 0000", bus.o_rsp_valid); end
    step();
    bus.i_req_valid[0] = 1'b0;
    @(negedge i_clk);
    vectors++; if (bus.o_rsp_valid !== '0) begin miscompares++; $display("FAIL rmid_eval_rsp got %b want 0000", bus.o_rsp_valid); end
    step();
    @(negedge i_clk);
    vectors++; if (bus.o_rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL rmid_rsp0 got %b want 0001", bus.o_rsp_valid); end
    vectors++; if (bus.o_rsp_result !== 1'b1) begin miscompares++; $display("FAIL rmid_result0 got %b want 1", bus.o_rsp_result); end
    bus.i_rsp_ready = 4'b0001;
    step();
    bus.i_rsp_ready = '0;
    bus.i_req_valid = '0;
    ptr_m = 1;
  endtask

  task automatic test_random();
    logic busy_m = 1'b0;
    int age = 0;
    int g_m = 0;
    logic res_m = 1'b0;
    int txns = 0;
    int cyc = 0;
    int wg;
    int granted;
    int wait_cnt [N];
    logic [N-1:0] exp_ready, exp_rsp;
    logic [W-1:0] a;
    i_rsn = 1'b0;
    bus.i_req_valid = '0;
    bus.i_rsp_ready = '0;
    step();
    i_rsn = 1'b1;
    ptr_m = 0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    while (txns < 1000 && cyc < 20000) begin
      @(negedge i_clk);
      cyc++;
      exp_ready = '0;
      exp_rsp = '0;
      wg = -1;
      granted = -1;
      if (!busy_m) begin
        wg = winner(bus.i_req_valid, ptr_m);
        if (wg >= 0) exp_ready[wg] = 1'b1;
      end else if (age == 2) exp_rsp[g_m] = 1'b1;
      vectors++; if (bus.o_req_ready !== exp_ready) begin miscompares++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, bus.o_req_ready, exp_ready); end
      vectors++; if (bus.o_rsp_valid !== exp_rsp) begin miscompares++; $display("FAIL rand_rsp_valid cyc %0d got %b want %b", cyc, bus.o_rsp_valid, exp_rsp); end
      vectors++; if (bus.o_busy !== busy_m) begin miscompares++; $display("FAIL rand_busy cyc %0d got %b want %b", cyc, bus.o_busy, busy_m); end
      if (busy_m && age == 2) begin
        vectors++; if (bus.o_rsp_result !== res_m) begin miscompares++; $display("FAIL rand_result cyc %0d got %b want %b", cyc, bus.o_rsp_result, res_m); end
      end
      if (!busy_m && wg >= 0) begin
        for (int k = 0; k < N; k++) if (k != wg && bus.i_req_valid[k]) begin
          wait_cnt[k]++;
          vectors++; if (wait_cnt[k] > N - 1) begin miscompares++; $display("FAIL rand_starve req %0d got %0d intervening grants want <= %0d", k, wait_cnt[k], N - 1); end
        end
        wait_cnt[wg] = 0;
        busy_m = 1'b1;
        age = 1;
        g_m = wg;
        res_m = opa[wg] > opb[wg];
        granted = wg;
      end else if (busy_m && age == 1) age = 2;
      else if (busy_m && bus.i_rsp_ready[g_m]) begin
        busy_m = 1'b0;
        age = 0;
        ptr_m = (g_m + 1) % N;
        txns++;
      end
      step();
      if (granted >= 0) bus.i_req_valid[granted] = 1'b0;
      for (int k = 0; k < N; k++) if (!bus.i_req_valid[k] && $urandom_range(0, 2) == 0) begin
        a = $urandom;
        set_req(k, a, ($urandom_range(0, 3) == 0) ? a : W'($urandom));
      end
      bus.i_rsp_ready = N'($urandom);
    end
    vectors++; if (txns < 1000) begin miscompares++; $display("FAIL rand_timeout got %0d transactions want 1000", txns); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
